// File: rtl/bram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// bram_fifo_ctrl : FIFO controller around a simple dual-port BRAM with
//                  registered read, plus a 2-entry output skid buffer.
// Revision       : 1.0 initial release
// ============================================================================
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  bram_wr,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data
);

  localparam int                DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [1:0] OB_EMPTY = 2'd0;
  localparam logic [1:0] OB_ONE   = 2'd1;
  localparam logic [1:0] OB_TWO   = 2'd2;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  rd_pending_q;
  logic [1:0]            ob_count_q, ob_count_d;
  logic [DATA_WIDTH-1:0] ob_head_q, ob_head_d, ob_tail_q, ob_tail_d;

  logic       in_fire, out_fire, rd_issue, capture;
  logic [2:0] ob_future;

  assign in_ready  = (mem_count_q != FULL_COUNT) & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (ob_count_q != OB_EMPTY) & ~rst;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = ob_head_q;

  // Occupancy the buffer will have once the current read lands and the current pop leaves.
  assign ob_future = {1'b0, ob_count_q} + {2'b00, rd_pending_q} - {2'b00, out_fire};
  assign rd_issue  = (mem_count_q != '0) & (ob_future <= 3'd1);
  assign capture   = rd_pending_q;

  assign bram_wr      = in_fire;
  assign bram_wr_addr = wr_ptr_q;
  assign bram_wr_data = in_data;
  assign bram_rd_addr = rd_ptr_q;

  assign level = rst ? '0
               : ({1'b0, mem_count_q}
                + {{(ADDR_WIDTH+1){1'b0}}, rd_pending_q}
                + {{ADDR_WIDTH{1'b0}}, ob_count_q});

  always_comb begin
    mem_count_d = mem_count_q;
    case ({in_fire, rd_issue})
      2'b10:   mem_count_d = mem_count_q + 1'b1;
      2'b01:   mem_count_d = mem_count_q - 1'b1;
      default: mem_count_d = mem_count_q;
    endcase
  end

  always_comb begin
    ob_count_d = ob_count_q;
    ob_head_d  = ob_head_q;
    ob_tail_d  = ob_tail_q;
    case (ob_count_q)
      OB_EMPTY: begin
        if (capture) begin
          ob_head_d  = bram_rd_data;
          ob_count_d = OB_ONE;
        end
      end
      OB_ONE: begin
        if (capture && out_fire) begin
          ob_head_d = bram_rd_data;
        end else if (capture) begin
          ob_tail_d  = bram_rd_data;
          ob_count_d = OB_TWO;
        end else if (out_fire) begin
          ob_count_d = OB_EMPTY;
        end
      end
      OB_TWO: begin
        if (out_fire) begin
          ob_head_d = ob_tail_q;
          if (capture) ob_tail_d = bram_rd_data;
          else         ob_count_d = OB_ONE;
        end
      end
      default: ob_count_d = OB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      rd_pending_q <= 1'b0;
      ob_count_q   <= OB_EMPTY;
    end else begin
      if (in_fire)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      mem_count_q  <= mem_count_d;
      rd_pending_q <= rd_issue;
      ob_count_q   <= ob_count_d;
    end
  end

  // Payload registers carry no reset; their content is meaningless while empty.
  always_ff @(posedge clk) begin
    ob_head_q <= ob_head_d;
    ob_tail_q <= ob_tail_d;
  end

endmodule
`default_nettype wire

// File: doc/bram_fifo_ctrl.md
BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning BRAM address bits; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream word.
REQ-008 SHALL have port out_valid  output  1  out_data holds valid word.
REQ-009 SHALL have port out_ready  input  1  downstream takes word this cycle.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  oldest stored word.
REQ-011 SHALL have port level  output  ADDR_WIDTH+2  total words held (BRAM + read in flight + output buffer).
REQ-012 SHALL have port bram_wr  output  1  write strobe to BRAM write port (port A).
REQ-013 SHALL have port bram_wr_addr  output  ADDR_WIDTH  write address to port A.
REQ-014 SHALL have port bram_wr_data  output  DATA_WIDTH  write data to port A.
REQ-015 SHALL have port bram_rd_addr  output  ADDR_WIDTH  read address to port B (port B write tied 0 externally).
REQ-016 SHALL have port bram_rd_data  input  DATA_WIDTH  port B registered read data, valid one cycle after address.

Function
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (mem_count != DEPTH) & ~rst, combinationally from registers.
REQ-019 SHALL drive bram_wr = in_fire, bram_wr_addr = wr_ptr, bram_wr_data = in_data, combinationally.
REQ-020 SHALL increment wr_ptr modulo DEPTH on in_fire (wrap DEPTH-1 -> 0).
REQ-021 SHALL drive bram_rd_addr = rd_ptr at all times.
REQ-022 SHALL assert internal rd_issue when mem_count != 0 and (ob_count + rd_pending - out_fire) <= 1; rd_ptr increments modulo DEPTH on rd_issue.
REQ-023 SHALL register rd_pending <= rd_issue; when rd_pending = 1, bram_rd_data SHALL be captured into the output buffer that cycle.
REQ-024 SHALL update mem_count (0..DEPTH) by +in_fire -rd_issue each cycle; simultaneous write and read leaves it unchanged.
REQ-025 SHALL implement a 2-entry output buffer with states EMPTY (ob_count 0), ONE (1), TWO (2); head entry drives out_data.
REQ-026 SHALL transition: capture only -> +1 state; out_fire only -> -1 state (TWO shifts second entry to head); capture and out_fire together -> same state, order preserved.
REQ-027 SHALL drive out_valid = (ob_count != 0); out_data SHALL hold steady while out_valid & ~out_ready.
REQ-028 SHALL never overflow the output buffer; REQ-022 guarantees ob_count + rd_pending <= 2.
REQ-029 SHALL deliver words in exact acceptance order, no loss or duplication, across pointer wrap.
REQ-030 SHALL give latency in_fire at cycle t (empty block) -> out_valid high in cycle t+3.
REQ-031 SHALL sustain one word per cycle throughput in steady state when out_ready held high.
REQ-032 SHALL drive level = mem_count + rd_pending + ob_count; maximum DEPTH+2.
REQ-033 SHALL ignore in_valid when in_ready = 0 (no write, no pointer change).

Reset
REQ-034 SHALL on rst clear wr_ptr, rd_ptr, mem_count, rd_pending, ob_count to 0; out_valid, in_ready, bram_wr, level = 0 during reset.
REQ-035 SHALL discard all stored and in-flight words on rst mid-operation; in-flight read data SHALL not be captured.
REQ-036 SHALL not require BRAM contents to be cleared; out_data value while out_valid = 0 is don't-care.

Verification
REQ-037 Single word: reset, write 0xA5 at cycle t, out_ready=1 -> out_valid in t+3 with out_data 0xA5, level 0 afterwards.
REQ-038 Fill: out_ready=0, write DEPTH+2 words 0..17 (defaults) -> in_ready drops after 18 accepted, level = 18, out_data = 0.
REQ-039 Streaming: in_valid and out_ready both 1 for 100 cycles with incrementing data -> one word out per cycle after latency, order intact, pointers wrap correctly.
REQ-040 Backpressure: random out_ready toggling with continuous writes -> out_data stable while stalled, scoreboard matches, no overflow.
REQ-041 Reset mid-operation: rst asserted with level 10 and a read in flight -> next cycle out_valid 0, level 0; subsequent word 0x3C emerges first.
REQ-042 Simultaneous events: full block, single out_fire -> in_ready rises within 2 cycles, concurrent in_fire and rd_issue keep mem_count constant.
